// File: rtl/mc_ctrl_pkg.sv
// Shared constants for the multicycle control unit: state codes, opcode/funct
// encodings, ALU operation codes, trap causes and the funct/opcode decoders.
package mc_ctrl_pkg;

    localparam logic [4:0] S_IF      = 5'd0;
    localparam logic [4:0] S_ID      = 5'd1;
    localparam logic [4:0] S_MEM_ADR = 5'd2;
    localparam logic [4:0] S_MEM_RD  = 5'd3;
    localparam logic [4:0] S_LW_WB   = 5'd4;
    localparam logic [4:0] S_MEM_WR  = 5'd5;
    localparam logic [4:0] S_R_EXE   = 5'd6;
    localparam logic [4:0] S_R_WB    = 5'd7;
    localparam logic [4:0] S_BR      = 5'd8;
    localparam logic [4:0] S_JMP     = 5'd9;
    localparam logic [4:0] S_I_EXE   = 5'd10;
    localparam logic [4:0] S_I_WB    = 5'd11;
    localparam logic [4:0] S_JAL     = 5'd12;
    localparam logic [4:0] S_TRAP    = 5'd13;
    localparam logic [4:0] S_ERET    = 5'd14;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_COP0  = 6'h10;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_ERET = 6'h18;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b011;
    localparam logic [2:0] ALU_NOR = 3'b100;
    localparam logic [2:0] ALU_SRL = 3'b101;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] CAUSE_EXT = 2'b00;
    localparam logic [1:0] CAUSE_ILL = 2'b01;
    localparam logic [1:0] CAUSE_OVF = 2'b10;
    localparam logic [1:0] CAUSE_BUS = 2'b11;

    function automatic logic r_funct_legal(input logic [5:0] funct);
        case (funct)
            F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR,
            F_XOR, F_NOR, F_SLT, F_SRL: return 1'b1;
            default:                    return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] r_alu_op(input logic [5:0] funct);
        case (funct)
            F_SUB, F_SUBU: return ALU_SUB;
            F_AND:         return ALU_AND;
            F_OR:          return ALU_OR;
            F_XOR:         return ALU_XOR;
            F_NOR:         return ALU_NOR;
            F_SLT:         return ALU_SLT;
            F_SRL:         return ALU_SRL;
            default:       return ALU_ADD;
        endcase
    endfunction

    function automatic logic [2:0] i_alu_op(input logic [5:0] op);
        case (op)
            OP_SLTI: return ALU_SLT;
            OP_ANDI: return ALU_AND;
            OP_ORI:  return ALU_OR;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Counts consecutive stalled cycles of a memory state; expired flags that the
// stall budget is used up.
module mc_wait_timer #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic hold,
    input  logic clear,
    output logic expired
);
    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    logic [CW-1:0] count_reg;

    assign expired = (count_reg == CW'(MEM_TIMEOUT));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (hold && !expired) begin
            count_reg <= count_reg + CW'(1);
        end
    end

endmodule

// File: rtl/mc_ctrl_int.sv
// Multicycle MIPS control FSM with memory wait-state tolerance, bus timeout,
// external interrupts, precise illegal/overflow traps and eret.
module mc_ctrl_int
    import mc_ctrl_pkg::*;
#(
    parameter int   MEM_TIMEOUT = 255,
    parameter logic IE_RESET    = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Inst_in,
    input  logic        zero,
    input  logic        overflow,
    input  logic        MIO_ready,
    input  logic        INT,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IorD,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic        ALUSrcA,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic        Branch,
    output logic        CPU_MIO,
    output logic [1:0]  RegDst,
    output logic [1:0]  MemtoReg,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  PCSource,
    output logic [2:0]  ALU_operation,
    output logic        EPCWrite,
    output logic        EpcSel,
    output logic        IntAck,
    output logic [1:0]  Cause,
    output logic        IE,
    output logic [4:0]  state_out
);
    logic [4:0] state_reg, state_next;
    logic [1:0] cause_reg, cause_next;
    logic       ie_reg;
    logic [5:0] op, funct;
    logic       wait_expired, wait_hold, wait_clear;
    logic       insn_done;
    logic       unused_inputs;

    assign op            = Inst_in[31:26];
    assign funct         = Inst_in[5:0];
    // Branch polarity and the zero flag are combined in the datapath.
    assign unused_inputs = ^{Inst_in[25:6], zero};

    assign wait_hold  = ((state_reg == S_IF) || (state_reg == S_MEM_RD) ||
                         (state_reg == S_MEM_WR)) && !MIO_ready;
    assign wait_clear = (state_next != state_reg);

    mc_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_wait_timer (
        .clk    (clk),
        .reset  (reset),
        .hold   (wait_hold),
        .clear  (wait_clear),
        .expired(wait_expired)
    );

    always_comb begin
        state_next = state_reg;
        cause_next = cause_reg;
        insn_done  = 1'b0;
        case (state_reg)
            S_IF: begin
                if (MIO_ready) begin
                    state_next = S_ID;
                end else if (wait_expired) begin
                    state_next = S_TRAP;
                    cause_next = CAUSE_BUS;
                end
            end
            S_ID: begin
                case (op)
                    OP_RTYPE: begin
                        if (r_funct_legal(funct)) begin
                            state_next = S_R_EXE;
                        end else begin
                            state_next = S_TRAP;
                            cause_next = CAUSE_ILL;
                        end
                    end
                    OP_COP0: begin
                        if (funct == F_ERET) begin
                            state_next = S_ERET;
                        end else begin
                            state_next = S_TRAP;
                            cause_next = CAUSE_ILL;
                        end
                    end
                    OP_LW, OP_SW:   state_next = S_MEM_ADR;
                    OP_BEQ, OP_BNE: state_next = S_BR;
                    OP_J:           state_next = S_JMP;
                    OP_JAL:         state_next = S_JAL;
                    OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI:
                                    state_next = S_I_EXE;
                    default: begin
                        state_next = S_TRAP;
                        cause_next = CAUSE_ILL;
                    end
                endcase
            end
            S_MEM_ADR: state_next = (op == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: begin
                if (MIO_ready) begin
                    state_next = S_LW_WB;
                end else if (wait_expired) begin
                    state_next = S_TRAP;
                    cause_next = CAUSE_BUS;
                end
            end
            S_MEM_WR: begin
                if (MIO_ready) begin
                    insn_done = 1'b1;
                end else if (wait_expired) begin
                    state_next = S_TRAP;
                    cause_next = CAUSE_BUS;
                end
            end
            S_R_EXE: begin
                // Only the trapping adds/subs raise overflow; writeback is skipped.
                if (overflow && ((funct == F_ADD) || (funct == F_SUB))) begin
                    state_next = S_TRAP;
                    cause_next = CAUSE_OVF;
                end else begin
                    state_next = S_R_WB;
                end
            end
            S_I_EXE: begin
                if (overflow && (op == OP_ADDI)) begin
                    state_next = S_TRAP;
                    cause_next = CAUSE_OVF;
                end else begin
                    state_next = S_I_WB;
                end
            end
            S_LW_WB, S_R_WB, S_BR, S_JMP, S_I_WB, S_JAL: insn_done = 1'b1;
            S_TRAP, S_ERET: state_next = S_IF;
            default:        state_next = S_IF;
        endcase

        // External interrupts are only recognised at instruction boundaries.
        if (insn_done) begin
            if (INT && ie_reg) begin
                state_next = S_TRAP;
                cause_next = CAUSE_EXT;
            end else begin
                state_next = S_IF;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= S_IF;
            cause_reg <= CAUSE_EXT;
            ie_reg    <= IE_RESET;
        end else begin
            state_reg <= state_next;
            cause_reg <= cause_next;
            if (state_reg == S_TRAP) begin
                ie_reg <= 1'b0;
            end else if (state_reg == S_ERET) begin
                ie_reg <= 1'b1;
            end
        end
    end

    always_comb begin
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        IorD          = 1'b0;
        IRWrite       = 1'b0;
        RegWrite      = 1'b0;
        ALUSrcA       = 1'b0;
        PCWrite       = 1'b0;
        PCWriteCond   = 1'b0;
        Branch        = 1'b0;
        RegDst        = 2'b00;
        MemtoReg      = 2'b00;
        ALUSrcB       = 2'b00;
        PCSource      = 2'b00;
        ALU_operation = ALU_ADD;
        EPCWrite      = 1'b0;
        EpcSel        = 1'b0;
        IntAck        = 1'b0;
        case (state_reg)
            S_IF: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = MIO_ready;
                PCWrite = MIO_ready;
            end
            S_ID:      ALUSrcB = 2'b11;
            S_MEM_ADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEM_RD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_LW_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 2'b01;
            end
            S_MEM_WR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_R_EXE: begin
                ALUSrcA       = 1'b1;
                ALU_operation = r_alu_op(funct);
            end
            S_R_WB: begin
                RegWrite = 1'b1;
                RegDst   = 2'b01;
            end
            S_BR: begin
                ALUSrcA       = 1'b1;
                ALU_operation = ALU_SUB;
                PCWriteCond   = 1'b1;
                PCSource      = 2'b01;
                Branch        = (op == OP_BNE);
            end
            S_JMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            S_I_EXE: begin
                ALUSrcA       = 1'b1;
                ALUSrcB       = 2'b10;
                ALU_operation = i_alu_op(op);
            end
            S_I_WB: RegWrite = 1'b1;
            S_JAL: begin
                RegWrite = 1'b1;
                RegDst   = 2'b10;
                MemtoReg = 2'b10;
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            S_TRAP: begin
                EPCWrite = 1'b1;
                PCWrite  = 1'b1;
                PCSource = 2'b11;
                IntAck   = 1'b1;
            end
            S_ERET: begin
                PCWrite  = 1'b1;
                PCSource = 2'b11;
                EpcSel   = 1'b1;
            end
            default: ;
        endcase
    end

    assign CPU_MIO   = MemRead | MemWrite;
    assign Cause     = cause_reg;
    assign IE        = ie_reg;
    assign state_out = state_reg;

endmodule

// File: tb/tb_mc_ctrl_int.sv
// Directed-vector bench for mc_ctrl_int: instruction sequences, wait states,
// bus timeout, interrupt entry/eret, precise traps and asynchronous reset.
module tb_mc_ctrl_int;
    logic        clk;
    logic        reset;
    logic [31:0] Inst_in;
    logic        zero, overflow, MIO_ready, INT;
    logic        MemRead, MemWrite, IorD, IRWrite, RegWrite, ALUSrcA;
    logic        PCWrite, PCWriteCond, Branch, CPU_MIO;
    logic [1:0]  RegDst, MemtoReg, ALUSrcB, PCSource;
    logic [2:0]  ALU_operation;
    logic        EPCWrite, EpcSel, IntAck, IE;
    logic [1:0]  Cause;
    logic [4:0]  state_out;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [31:0] I_LW   = 32'h8C010004;
    localparam logic [31:0] I_SW   = 32'hAC010004;
    localparam logic [31:0] I_ADD  = 32'h00221820;
    localparam logic [31:0] I_SUB  = 32'h00221822;
    localparam logic [31:0] I_BNE  = 32'h14220003;
    localparam logic [31:0] I_J    = 32'h08000000;
    localparam logic [31:0] I_ERET = 32'h42000018;
    localparam logic [31:0] I_BADOP = 32'hFC000000;
    localparam logic [31:0] I_BADFN = 32'h00000001;

    mc_ctrl_int #(
        .MEM_TIMEOUT(4),
        .IE_RESET   (1'b0)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .Inst_in      (Inst_in),
        .zero         (zero),
        .overflow     (overflow),
        .MIO_ready    (MIO_ready),
        .INT          (INT),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .IorD         (IorD),
        .IRWrite      (IRWrite),
        .RegWrite     (RegWrite),
        .ALUSrcA      (ALUSrcA),
        .PCWrite      (PCWrite),
        .PCWriteCond  (PCWriteCond),
        .Branch       (Branch),
        .CPU_MIO      (CPU_MIO),
        .RegDst       (RegDst),
        .MemtoReg     (MemtoReg),
        .ALUSrcB      (ALUSrcB),
        .PCSource     (PCSource),
        .ALU_operation(ALU_operation),
        .EPCWrite     (EPCWrite),
        .EpcSel       (EpcSel),
        .IntAck       (IntAck),
        .Cause        (Cause),
        .IE           (IE),
        .state_out    (state_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, obs);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_state(input string tag, input logic [4:0] exp);
        tick();
        check(tag, 32'(state_out), 32'(exp));
    endtask

    initial begin
        reset = 1'b0; Inst_in = I_LW; zero = 1'b0; overflow = 1'b0;
        MIO_ready = 1'b1; INT = 1'b0;

        // Reset state
        #2;
        check("rst_state", 32'(state_out), 0);
        check("rst_memread", 32'(MemRead), 1);
        check("rst_cpu_mio", 32'(CPU_MIO), 1);
        check("rst_alusrcb", 32'(ALUSrcB), 1);
        check("rst_aluop", 32'(ALU_operation), 2);
        check("rst_pcsource", 32'(PCSource), 0);
        check("rst_irwrite_rdy", 32'(IRWrite), 1);
        check("rst_regwrite", 32'(RegWrite), 0);
        check("rst_cause", 32'(Cause), 0);
        check("rst_ie", 32'(IE), 0);
        MIO_ready = 1'b0;
        #1;
        check("rst_irwrite_nrdy", 32'(IRWrite), 0);
        check("rst_pcwrite_nrdy", 32'(PCWrite), 0);
        MIO_ready = 1'b1;
        #9 reset = 1'b1;

        // lw with zero wait states: 0,1,2,3,4,0
        tick_state("lw_id", 1);
        tick_state("lw_adr", 2);
        check("lw_adr_regwrite", 32'(RegWrite), 0);
        tick_state("lw_rd", 3);
        check("lw_rd_iord", 32'(IorD), 1);
        tick_state("lw_wb", 4);
        check("lw_wb_regwrite", 32'(RegWrite), 1);
        check("lw_wb_memtoreg", 32'(MemtoReg), 1);
        tick_state("lw_done", 0);

        // lw with 3 wait cycles in MEM_RD, below the timeout
        tick_state("lww_id", 1);
        tick_state("lww_adr", 2);
        MIO_ready = 1'b0;
        tick_state("lww_rd0", 3);
        tick_state("lww_rd1", 3);
        tick_state("lww_rd2", 3);
        tick_state("lww_rd3", 3);
        MIO_ready = 1'b1;
        check("lww_rd_memread", 32'(MemRead), 1);
        tick_state("lww_wb", 4);
        tick_state("lww_done", 0);

        // Ready arrives in the very cycle the counter hits the limit; INT masked
        Inst_in = I_J; INT = 1'b1; MIO_ready = 1'b0;
        for (int i = 0; i < 4; i++) tick_state("edge_if_hold", 0);
        MIO_ready = 1'b1;
        tick_state("edge_id", 1);
        tick_state("j_jmp", 9);
        check("j_pcsource", 32'(PCSource), 2);
        tick_state("j_masked_int", 0);
        INT = 1'b0;

        // Bus timeout in IF
        MIO_ready = 1'b0;
        for (int i = 0; i < 4; i++) tick_state("to_if_hold", 0);
        tick_state("to_trap", 13);
        check("to_cause", 32'(Cause), 3);
        check("to_intack", 32'(IntAck), 1);
        check("to_epcwrite", 32'(EPCWrite), 1);
        check("to_pcsource", 32'(PCSource), 3);
        check("to_epcsel", 32'(EpcSel), 0);
        MIO_ready = 1'b1;
        tick_state("to_if", 0);
        check("to_intack_pulse", 32'(IntAck), 0);

        // eret enables interrupts
        Inst_in = I_ERET;
        tick_state("eret1_id", 1);
        tick_state("eret1", 14);
        check("eret1_epcsel", 32'(EpcSel), 1);
        check("eret1_pcwrite", 32'(PCWrite), 1);
        tick_state("eret1_if", 0);
        check("eret1_ie", 32'(IE), 1);

        // add with INT raised in R_EXE: writeback completes, then TRAP
        Inst_in = I_ADD;
        tick_state("int_id", 1);
        tick_state("int_rexe", 6);
        check("int_aluop", 32'(ALU_operation), 2);
        INT = 1'b1;
        tick_state("int_rwb", 7);
        check("int_rwb_regwrite", 32'(RegWrite), 1);
        tick_state("int_trap", 13);
        check("int_epcwrite", 32'(EPCWrite), 1);
        check("int_cause", 32'(Cause), 0);
        INT = 1'b0;
        tick_state("int_if", 0);
        check("int_ie_cleared", 32'(IE), 0);
        Inst_in = I_ERET;
        tick_state("eret2_id", 1);
        tick_state("eret2", 14);
        check("eret2_epcsel", 32'(EpcSel), 1);
        tick_state("eret2_if", 0);
        check("eret2_ie", 32'(IE), 1);

        // Illegal funct
        Inst_in = I_BADFN;
        tick_state("badfn_id", 1);
        tick_state("badfn_trap", 13);
        check("badfn_cause", 32'(Cause), 1);
        tick_state("badfn_if", 0);

        // add overflow: trap, no writeback
        Inst_in = I_ADD;
        tick_state("ovf_id", 1);
        tick_state("ovf_rexe", 6);
        overflow = 1'b1;
        check("ovf_rexe_regwrite", 32'(RegWrite), 0);
        tick_state("ovf_trap", 13);
        check("ovf_cause", 32'(Cause), 2);
        check("ovf_trap_regwrite", 32'(RegWrite), 0);
        overflow = 1'b0;
        tick_state("ovf_if", 0);

        // Illegal opcode 0x3F
        Inst_in = I_BADOP;
        tick_state("badop_id", 1);
        tick_state("badop_trap", 13);
        check("badop_cause", 32'(Cause), 1);
        tick_state("badop_if", 0);

        // bne and sub decodes
        Inst_in = I_BNE;
        tick_state("bne_id", 1);
        tick_state("bne_br", 8);
        check("bne_branch", 32'(Branch), 1);
        check("bne_pcwritecond", 32'(PCWriteCond), 1);
        check("bne_aluop", 32'(ALU_operation), 6);
        tick_state("bne_if", 0);
        Inst_in = I_SUB;
        tick_state("sub_id", 1);
        tick_state("sub_rexe", 6);
        check("sub_aluop", 32'(ALU_operation), 6);
        tick_state("sub_rwb", 7);
        tick_state("sub_if", 0);

        // Asynchronous reset in MEM_WR
        Inst_in = I_SW;
        tick_state("sw_id", 1);
        tick_state("sw_adr", 2);
        tick_state("sw_wr", 5);
        check("sw_memwrite", 32'(MemWrite), 1);
        #2 reset = 1'b0;
        #1;
        check("arst_state", 32'(state_out), 0);
        check("arst_memwrite", 32'(MemWrite), 0);
        check("arst_cause", 32'(Cause), 0);
        check("arst_ie", 32'(IE), 0);
        #3 reset = 1'b1;
        tick_state("arst_resume", 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
